tv_checker: RTL and testbench

- Synthesizable test-vector player/checker for registered datapath blocks (flopenr-class registers with enable and reset).
- Reads packed vectors from a synchronous vector ROM and drives stimulus into the DUT.
- Compares the DUT output against the expected value and counts mismatches.
- Provides in-silicon/FPGA self-check of datapath registers, replacing simulation-only vector benches.

---
 rtl/tv_checker.sv | 167 ++++++++++++++++
 tb/tb_tv_checker.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/tv_checker.sv
// rtl/tv_checker.sv - test-vector player/checker for registered datapath blocks
`timescale 1ns/1ps
module tv_checker #(
  parameter int DW  = 32,
  parameter int AW  = 4,
  parameter int LAT = 1,
  parameter int VW  = 2*DW+3
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          start,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd,
  input  logic [VW-1:0] mem_rdata,
  output logic          dut_rst,
  output logic          dut_en,
  output logic [DW-1:0] dut_d,
  input  logic [DW-1:0] dut_q,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [AW:0]   vec_count,
  output logic [AW:0]   err_count,
  output logic [AW-1:0] first_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_DRIVE, S_WAIT, S_CHECK, S_DONE
  } state_t;

  localparam logic [3:0] LAT_L = 4'(LAT);

  state_t        r_state;
  logic [AW-1:0] r_idx;
  logic [DW-1:0] r_exp;
  logic [3:0]    r_wait;
  logic [AW-1:0] r_mem_addr;
  logic          r_mem_rd;
  logic          r_dut_rst;
  logic          r_dut_en;
  logic [DW-1:0] r_dut_d;
  logic          r_busy;
  logic          r_done;
  logic          r_pass;
  logic [AW:0]   r_vec_count;
  logic [AW:0]   r_err_count;
  logic [AW-1:0] r_first_err;

  // Vector fields: {valid, rst, en, d, q_exp}
  logic          w_vld;
  logic          w_rst;
  logic          w_en;
  logic [DW-1:0] w_d;
  logic [DW-1:0] w_q_exp;
  logic          w_mismatch;
  logic [AW:0]   w_err_next;
  logic          w_last;

  assign w_vld      = mem_rdata[VW-1];
  assign w_rst      = mem_rdata[VW-2];
  assign w_en       = mem_rdata[VW-3];
  assign w_d        = mem_rdata[2*DW-1:DW];
  assign w_q_exp    = mem_rdata[DW-1:0];
  assign w_mismatch = (dut_q != r_exp);
  // Error counter saturates at all-ones rather than wrapping back to zero
  assign w_err_next = (w_mismatch && !(&r_err_count)) ? r_err_count + (AW+1)'(1) : r_err_count;
  assign w_last     = &r_idx;

  assign mem_addr  = r_mem_addr;
  assign mem_rd    = r_mem_rd;
  assign dut_rst   = r_dut_rst;
  assign dut_en    = r_dut_en;
  assign dut_d     = r_dut_d;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign vec_count = r_vec_count;
  assign err_count = r_err_count;
  assign first_err = r_first_err;

  // Sequencer: read vector, drive stimulus, wait LAT cycles, compare, advance
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_exp       <= '0;
      r_wait      <= '0;
      r_mem_addr  <= '0;
      r_mem_rd    <= 1'b0;
      r_dut_rst   <= 1'b0;
      r_dut_en    <= 1'b0;
      r_dut_d     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_vec_count <= '0;
      r_err_count <= '0;
      r_first_err <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state     <= S_READ;
            r_idx       <= '0;
            r_vec_count <= '0;
            r_err_count <= '0;
            r_first_err <= '0;
            r_mem_addr  <= '0;
            r_mem_rd    <= 1'b1;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
          end
        end
        S_READ: begin
          r_mem_rd <= 1'b0;
          r_state  <= S_DRIVE;
        end
        S_DRIVE: begin
          if (!w_vld) begin
            // Terminator vector: finish without a check
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (r_err_count == '0);
          end else begin
            r_dut_rst <= w_rst;
            r_dut_en  <= w_en;
            r_dut_d   <= w_d;
            r_exp     <= w_q_exp;
            r_wait    <= LAT_L;
            r_state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          r_wait <= r_wait - 4'd1;
          if (r_wait == 4'd1) begin
            r_state <= S_CHECK;
          end
        end
        S_CHECK: begin
          r_err_count <= w_err_next;
          r_vec_count <= r_vec_count + (AW+1)'(1);
          if (w_mismatch && (r_err_count == '0)) begin
            r_first_err <= r_idx;
          end
          if (w_last) begin
            // Table exhausted; address never wraps back to 0
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (w_err_next == '0);
          end else begin
            r_idx      <= r_idx + AW'(1);
            r_mem_addr <= r_idx + AW'(1);
            r_mem_rd   <= 1'b1;
            r_state    <= S_READ;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tv_checker.sv
// tb/tb_tv_checker.sv - directed vector bench for tv_checker with flopenr32 model
`timescale 1ns/1ps
module tb_tv_checker;

  localparam int DW  = 32;
  localparam int AW  = 4;
  localparam int LAT = 2;
  localparam int VW  = 2*DW+3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic [VW-1:0] mem_rdata = '0;
  logic          dut_rst;
  logic          dut_en;
  logic [DW-1:0] dut_d;
  logic [DW-1:0] dut_q = '0;
  logic          busy;
  logic          done;
  logic          pass;
  logic [AW:0]   vec_count;
  logic [AW:0]   err_count;
  logic [AW-1:0] first_err;

  logic [VW-1:0] rom [16];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  tv_checker #(.DW(DW), .AW(AW), .LAT(LAT)) u_dut (
    .clk_in    (clk),
    .rst_in    (rst_n),
    .start     (start),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_rdata (mem_rdata),
    .dut_rst   (dut_rst),
    .dut_en    (dut_en),
    .dut_d     (dut_d),
    .dut_q     (dut_q),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .vec_count (vec_count),
    .err_count (err_count),
    .first_err (first_err)
  );

  // Synchronous vector ROM
  always @(posedge clk) if (mem_rd) mem_rdata <= rom[mem_addr];

  // Reference flopenr32 under test
  always @(posedge clk) begin
    if (dut_rst) dut_q <= '0;
    else if (dut_en) dut_q <= dut_d;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Builds n valid vectors; vectors whose mask bit is set get a wrong q_exp
  task automatic build(input int n, input logic [15:0] mask);
    logic [DW-1:0] q;
    logic          r, e;
    logic [DW-1:0] d;
    q = '0;
    for (int i = 0; i < 16; i++) begin
      r = (i % 5 == 0);
      e = (i % 3 != 2);
      d = (i == 2) ? 32'h1 : 32'hDEADBEEF + 32'(i - 1) * 32'h11111111;
      if (r) q = '0;
      else if (e) q = d;
      if (i < n) rom[i] = {1'b1, r, e, d, q ^ {31'b0, mask[i]}};
      else       rom[i] = '0;
    end
  endtask

  typedef struct {
    int          n;
    logic [15:0] mask;
    int          poke;
    int          exp_vec;
    int          exp_err;
    int          exp_first;
    logic        exp_pass;
    int          exp_cyc;
    int          exp_last;
  } vec_t;

  vec_t tbl [6];

  // Starts a run, optionally pulses start again while busy, waits for done
  task automatic run_case(input vec_t v, input string tag);
    int cyc;
    build(v.n, v.mask);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk({tag, ".start_clear"}, {busy, mem_rd, 4'(mem_addr), 5'(vec_count), 5'(err_count), done},
        {1'b1, 1'b1, 4'd0, 5'd0, 5'd0, 1'b0});
    cyc = 0;
    while (!done && cyc < 300) begin
      start = (cyc == v.poke);
      @(posedge clk);
      #1;
      cyc++;
    end
    start = 1'b0;
    chk({tag, ".done"}, 64'(done), 64'd1);
    chk({tag, ".cycles"}, 64'(cyc), 64'(v.exp_cyc));
    chk({tag, ".vec_count"}, 64'(vec_count), 64'(v.exp_vec));
    chk({tag, ".err_count"}, 64'(err_count), 64'(v.exp_err));
    chk({tag, ".first_err"}, 64'(first_err), 64'(v.exp_first));
    chk({tag, ".pass"}, 64'(pass), 64'(v.exp_pass));
    chk({tag, ".busy"}, 64'(busy), 64'd0);
    chk({tag, ".last_addr"}, 64'(mem_addr), 64'(v.exp_last));
  endtask

  initial begin
    int cyc;
    //        n   mask      poke vec err first pass cyc last
    tbl[0] = '{3,  16'h0000, -1,  3,  0,  0,   1'b1, 17, 3};
    tbl[1] = '{3,  16'h0002,  6,  3,  1,  1,   1'b0, 17, 3};
    tbl[2] = '{16, 16'h0000, -1, 16,  0,  0,   1'b1, 80, 15};
    tbl[3] = '{16, 16'hFFFF, 40, 16, 16,  0,   1'b0, 80, 15};
    tbl[4] = '{0,  16'h0000, -1,  0,  0,  0,   1'b1, 2,  0};
    tbl[5] = '{7,  16'h0050, 10,  7,  2,  4,   1'b0, 37, 7};

    build(3, 16'h0);
    #23;
    chk("reset_outputs", {mem_addr, mem_rd, dut_rst, dut_en, dut_d, busy, done, pass,
                          vec_count, err_count, first_err}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Abort in WAIT of vector 2
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 0;
    while (cyc < 12) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("abort.pre_vec_count", 64'(vec_count), 64'd2);
    chk("abort.pre_busy", 64'(busy), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort.outputs_zero", {mem_addr, mem_rd, dut_rst, dut_en, dut_d, busy, done, pass,
                               vec_count, err_count, first_err}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      run_case(tbl[i], $sformatf("vec%0d", i));
    end

    // Restart from DONE after a failing run gives identical results
    run_case(tbl[1], "rerun1");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
